// File: rtl/router_reg.sv
// Datapath register stage of the 1x3 router: header capture, FIFO byte staging, full-hold and parity check.
// Define ROUTER_REG_LEN_CHECK_EN to add a payload length counter and the len_err output.
module router_reg #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  pkt_valid,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  fifo_full,
    input  logic                  detect_add,
    input  logic                  lfd_state,
    input  logic                  ld_state,
    input  logic                  full_state,
    input  logic                  laf_state,
    input  logic                  rst_int_reg,
    output logic                  parity_done,
    output logic                  low_pkt_valid,
    output logic                  err,
`ifdef ROUTER_REG_LEN_CHECK_EN
    output logic                  len_err,
`endif
    output logic [DATA_WIDTH-1:0] dout
);

    localparam int unsigned LEN_W = DATA_WIDTH - 2;

    logic [DATA_WIDTH-1:0] header_byte;
    logic [DATA_WIDTH-1:0] hold_byte;
    logic [DATA_WIDTH-1:0] int_parity;
    logic [DATA_WIDTH-1:0] pkt_parity;
    logic                  parity_done_q;
    logic                  parity_set_c;
    logic                  parity_rise_c;
    logic                  err_next_c;

    assign parity_set_c  = (ld_state && !fifo_full && !pkt_valid)
                         || (laf_state && low_pkt_valid && !parity_done);
    assign parity_rise_c = parity_done && !parity_done_q;

    // Header capture
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            header_byte <= '0;
        end else if (detect_add && pkt_valid) begin
            header_byte <= data_in;
        end
    end

    // FIFO data bus staging; a byte arriving while the FIFO is full is parked in hold_byte
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            dout      <= '0;
            hold_byte <= '0;
        end else if (lfd_state) begin
            dout <= header_byte;
        end else if (ld_state && !fifo_full) begin
            dout <= data_in;
        end else if (ld_state && fifo_full) begin
            hold_byte <= data_in;
        end else if (laf_state) begin
            dout <= hold_byte;
        end
    end

    // Running XOR over header and payload
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            int_parity <= '0;
        end else if (detect_add) begin
            int_parity <= '0;
        end else if (lfd_state) begin
            int_parity <= int_parity ^ header_byte;
        end else if (ld_state && pkt_valid && !full_state) begin
            int_parity <= int_parity ^ data_in;
        end
    end

    // Trailing parity byte from the source
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            pkt_parity <= '0;
        end else if (detect_add) begin
            pkt_parity <= '0;
        end else if (ld_state && !pkt_valid) begin
            pkt_parity <= data_in;
        end
    end

    // parity_done is sticky until the next header; parity_done_q finds its rising edge
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            parity_done   <= 1'b0;
            parity_done_q <= 1'b0;
        end else begin
            parity_done_q <= parity_done;
            if (detect_add) begin
                parity_done <= 1'b0;
            end else if (parity_set_c) begin
                parity_done <= 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            low_pkt_valid <= 1'b0;
        end else if (rst_int_reg) begin
            low_pkt_valid <= 1'b0;
        end else if (ld_state && !pkt_valid) begin
            low_pkt_valid <= 1'b1;
        end
    end

`ifdef ROUTER_REG_LEN_CHECK_EN
    logic [LEN_W-1:0] len_cnt;
    logic             len_mismatch_c;

    assign len_mismatch_c = (len_cnt != header_byte[DATA_WIDTH-1:2]);
    assign err_next_c     = (int_parity != pkt_parity) || len_mismatch_c;

    // Payload bytes accepted, compared against the header length field
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            len_cnt <= '0;
        end else if (detect_add) begin
            len_cnt <= '0;
        end else if (ld_state && pkt_valid) begin
            len_cnt <= len_cnt + LEN_W'(1);
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            len_err <= 1'b0;
        end else if (detect_add) begin
            len_err <= 1'b0;
        end else if (parity_rise_c) begin
            len_err <= len_mismatch_c;
        end
    end
`else
    assign err_next_c = (int_parity != pkt_parity);
`endif

    // Verdict latched once both parities are in place
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            err <= 1'b0;
        end else if (detect_add) begin
            err <= 1'b0;
        end else if (parity_rise_c) begin
            err <= err_next_c;
        end
    end

endmodule

// File: tb/tb_router_reg.sv
// Bench for router_reg: packet table driven through a modelled FSM strobe sequence, dout scoreboard,
// plus reset and multi-strobe sequences. Build with ROUTER_REG_LEN_CHECK_EN to cover len_err.
module tb_router_reg;

    logic       clock;
    logic       resetn;
    logic       pkt_valid;
    logic [7:0] data_in;
    logic       fifo_full;
    logic       detect_add;
    logic       lfd_state;
    logic       ld_state;
    logic       full_state;
    logic       laf_state;
    logic       rst_int_reg;
    logic       parity_done;
    logic       low_pkt_valid;
    logic       err;
    logic [7:0] dout;
`ifdef ROUTER_REG_LEN_CHECK_EN
    logic       len_err;
`endif

    router_reg #(.DATA_WIDTH(8)) dut (
        .clock         (clock),
        .resetn        (resetn),
        .pkt_valid     (pkt_valid),
        .data_in       (data_in),
        .fifo_full     (fifo_full),
        .detect_add    (detect_add),
        .lfd_state     (lfd_state),
        .ld_state      (ld_state),
        .full_state    (full_state),
        .laf_state     (laf_state),
        .rst_int_reg   (rst_int_reg),
        .parity_done   (parity_done),
        .low_pkt_valid (low_pkt_valid),
        .err           (err),
`ifdef ROUTER_REG_LEN_CHECK_EN
        .len_err       (len_err),
`endif
        .dout          (dout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    localparam logic [5:0] S_IDLE = 6'b000000;
    localparam logic [5:0] S_DA   = 6'b000001;
    localparam logic [5:0] S_LFD  = 6'b000010;
    localparam logic [5:0] S_LD   = 6'b000100;
    localparam logic [5:0] S_FS   = 6'b001000;
    localparam logic [5:0] S_LAF  = 6'b010000;
    localparam logic [5:0] S_RIR  = 6'b100000;
    localparam logic [2:0] NO_STALL = 3'd7;

    typedef struct packed {
        logic [7:0]      hdr;
        logic [3:0][7:0] pay;
        logic [2:0]      npay;
        logic [7:0]      par;
        logic [2:0]      stall_idx;  // byte index (npay = parity byte) that meets fifo_full
        logic [1:0]      stall_len;  // FIFO_FULL_STATE cycles before LOAD_AFTER_FULL
        logic            exp_err;
        logic            exp_len_err;
    } pkt_t;

    int         tests = 0;
    int         fails = 0;
    logic [7:0] sbq[$];
    logic [7:0] last_dout;
    pkt_t       tbl[9];

    function automatic pkt_t mk(input logic [7:0] hdr, input logic [7:0] p0, input logic [7:0] p1,
                                input logic [7:0] p2, input logic [7:0] p3, input logic [2:0] npay,
                                input logic [7:0] par, input logic [2:0] sidx, input logic [1:0] slen,
                                input logic e, input logic le);
        pkt_t p;
        p.hdr = hdr;
        p.pay[0] = p0;
        p.pay[1] = p1;
        p.pay[2] = p2;
        p.pay[3] = p3;
        p.npay = npay;
        p.par = par;
        p.stall_idx = sidx;
        p.stall_len = slen;
        p.exp_err = e;
        p.exp_len_err = le;
        return p;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input logic [5:0] s, input logic pv, input logic full, input logic [7:0] d);
        {rst_int_reg, laf_state, full_state, ld_state, lfd_state, detect_add} = s;
        pkt_valid = pv;
        fifo_full = full;
        data_in   = d;
        @(posedge clock);
        #1;
    endtask

    task automatic pop_check(input string name);
        logic [7:0] exp;
        if (sbq.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL %s: dout %h written with no expected byte queued", name, dout);
        end else begin
            exp = sbq.pop_front();
            check(name, dout, exp);
            last_dout = exp;
        end
    endtask

    // Models router_fsm strobes for one packet; expected dout stream is queued up front
    task automatic send_pkt(input pkt_t p);
        int         nbytes;
        logic       last;
        logic [7:0] b;
        nbytes = int'(p.npay) + 1;
        sbq.push_back(p.hdr);
        for (int i = 0; i < int'(p.npay); i++) sbq.push_back(p.pay[i]);
        sbq.push_back(p.par);

        cyc(S_DA, 1'b1, 1'b0, p.hdr);
        check("err_clr_on_hdr", 8'(err), 8'h00);
        check("pd_clr_on_hdr", 8'(parity_done), 8'h00);
        cyc(S_LFD, 1'b1, 1'b0, p.pay[0]);
        pop_check("dout_header");
        for (int i = 0; i < nbytes; i++) begin
            last = (i == nbytes - 1);
            b = last ? p.par : p.pay[i];
            if (i == int'(p.stall_idx)) begin
                cyc(S_LD, !last, 1'b1, b);
                check("dout_held_ld", dout, last_dout);
                for (int k = 0; k < int'(p.stall_len); k++) begin
                    cyc(S_FS, !last, 1'b1, 8'hFF);
                    check("dout_held_full", dout, last_dout);
                end
                cyc(S_LAF, !last, 1'b0, 8'hFF);
                pop_check("dout_laf");
            end else begin
                cyc(S_LD, !last, 1'b0, b);
                pop_check("dout_ld");
            end
        end
        check("parity_done", 8'(parity_done), 8'h01);
        check("low_pkt_valid_set", 8'(low_pkt_valid), 8'h01);
        cyc(S_IDLE, 1'b0, 1'b0, 8'h00);
        check("err", 8'(err), 8'(p.exp_err));
`ifdef ROUTER_REG_LEN_CHECK_EN
        check("len_err", 8'(len_err), 8'(p.exp_len_err));
`endif
        cyc(S_RIR, 1'b0, 1'b0, 8'h00);
        check("low_pkt_valid_clr", 8'(low_pkt_valid), 8'h00);
        check("err_hold_chk", 8'(err), 8'(p.exp_err));
        check("sb_drained", 8'(sbq.size()), 8'h00);
        sbq.delete();
    endtask

    task automatic async_reset(input string name);
        #2 resetn = 1'b0;
        #1;
        check({name, "_dout"}, dout, 8'h00);
        check({name, "_pd"}, 8'(parity_done), 8'h00);
        check({name, "_lpv"}, 8'(low_pkt_valid), 8'h00);
        check({name, "_err"}, 8'(err), 8'h00);
        @(posedge clock);
        #1 resetn = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0;
        {rst_int_reg, laf_state, full_state, ld_state, lfd_state, detect_add} = S_IDLE;
        pkt_valid = 1'b0;
        fifo_full = 1'b0;
        data_in   = 8'h00;
        last_dout = 8'h00;

        //            hdr    p0     p1     p2     p3    n     par    stall     slen  err   len_err
        tbl[0] = mk(8'h05, 8'hA3, 8'h00, 8'h00, 8'h00, 3'd1, 8'hA6, NO_STALL, 2'd0, 1'b0, 1'b0);
        tbl[1] = mk(8'h05, 8'hA3, 8'h00, 8'h00, 8'h00, 3'd1, 8'hA7, NO_STALL, 2'd0, 1'b1, 1'b0);
        tbl[2] = mk(8'h05, 8'hA3, 8'h00, 8'h00, 8'h00, 3'd1, 8'hA6, NO_STALL, 2'd0, 1'b0, 1'b0);
        tbl[3] = mk(8'h0E, 8'h11, 8'h22, 8'h33, 8'h00, 3'd3, 8'h0E, 3'd1,     2'd2, 1'b0, 1'b0);
        tbl[4] = mk(8'h0E, 8'h11, 8'h22, 8'h33, 8'h00, 3'd3, 8'h3E, 3'd0,     2'd1, 1'b1, 1'b0);
        tbl[5] = mk(8'h09, 8'h5A, 8'hC3, 8'h00, 8'h00, 3'd2, 8'h90, 3'd2,     2'd1, 1'b0, 1'b0);
        tbl[6] = mk(8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 3'd0, 8'h02, NO_STALL, 2'd0, 1'b0, 1'b0);
        tbl[7] = mk(8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 3'd0, 8'h00, 3'd0,     2'd0, 1'b1, 1'b0);
`ifdef ROUTER_REG_LEN_CHECK_EN
        tbl[8] = mk(8'h08, 8'h01, 8'h02, 8'h04, 8'h00, 3'd3, 8'h0F, NO_STALL, 2'd0, 1'b1, 1'b1);
`else
        tbl[8] = mk(8'h08, 8'h01, 8'h02, 8'h04, 8'h00, 3'd3, 8'h0F, NO_STALL, 2'd0, 1'b0, 1'b0);
`endif

        repeat (2) @(posedge clock);
        #1;
        check("rst_dout", dout, 8'h00);
        check("rst_pd", 8'(parity_done), 8'h00);
        check("rst_lpv", 8'(low_pkt_valid), 8'h00);
        check("rst_err", 8'(err), 8'h00);
        resetn = 1'b1;
        @(posedge clock);
        #1;

        for (int i = 0; i < 9; i++) send_pkt(tbl[i]);

        // Reset with err and parity_done high
        send_pkt(tbl[1]);
        async_reset("rst_after_err");

        // Reset mid-payload, then a clean packet
        cyc(S_DA, 1'b1, 1'b0, 8'h0E);
        cyc(S_LFD, 1'b1, 1'b0, 8'h11);
        cyc(S_LD, 1'b1, 1'b0, 8'h11);
        check("mid_dout", dout, 8'h11);
        async_reset("rst_mid");
        send_pkt(tbl[0]);

        // Illegal simultaneous strobes follow dout priority
        cyc(S_LFD | S_LD, 1'b1, 1'b0, 8'h5C);
        check("ms_lfd_ld", dout, 8'h05);
        cyc(S_LD | S_LAF, 1'b1, 1'b0, 8'h6D);
        check("ms_ld_laf", dout, 8'h6D);
        cyc(S_LD | S_LAF, 1'b1, 1'b1, 8'h77);
        check("ms_ldfull_laf", dout, 8'h6D);
        cyc(S_LAF, 1'b1, 1'b0, 8'h00);
        check("ms_laf_hold", dout, 8'h77);
        check("ms_known", 8'($isunknown(dout)), 8'h00);
        cyc(S_RIR, 1'b0, 1'b0, 8'h00);
        send_pkt(tbl[3]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
